// File: rtl/rv32i_pkg.sv
// Shared RV32I constants for the loader encoder: opcode7 values, NOP word,
// field bundle type and encoder FSM states.
package rv32i_pkg;

  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_I     = 7'b0010011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_S     = 7'b0100011;
  localparam logic [6:0]  OP_B     = 7'b1100011;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  // opcode packs {funct7[5:0], funct3, opcode7}, matching the decode stage
  typedef struct packed {
    logic [15:0] opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } inst_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_t;

endpackage

// File: rtl/inst_encode_pack.sv
// Combinational field packer: decoded fields -> 32-bit RV32I word.
// INST_ENCODE_RANGE_CHECK_EN adds immediate/funct7 range checks that force a NOP.
module inst_pack
  import rv32i_pkg::*;
(
  input  inst_fields_t fields,
  output logic [31:0]  word,
  output logic         illegal,
  output logic         range_fault
);

  logic [6:0]  op;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] imm;
  logic [31:0] raw;

  assign op  = fields.opcode[6:0];
  assign f7  = {1'b0, fields.opcode[15:10]};
  assign f3  = fields.opcode[9:7];
  assign imm = fields.imm;

  always_comb begin
    raw     = '0;
    illegal = 1'b0;
    unique case (op)
      OP_R:              raw = {f7, fields.rs2, fields.rs1, f3, fields.rd, op};
      OP_I, OP_LOAD:     raw = {imm[11:0], fields.rs1, f3, fields.rd, op};
      OP_JALR:           raw = {imm[11:0], fields.rs1, 3'b000, fields.rd, op};
      OP_S:              raw = {imm[11:5], fields.rs2, fields.rs1, f3, imm[4:0], op};
      OP_B:              raw = {imm[12], imm[10:5], fields.rs2, fields.rs1, f3,
                                imm[4:1], imm[11], op};
      OP_LUI, OP_AUIPC:  raw = {imm[31:12], fields.rd, op};
      OP_JAL:            raw = {imm[20], imm[10:1], imm[11], imm[19:12], fields.rd, op};
      default:           illegal = 1'b1;
    endcase
  end

`ifdef INST_ENCODE_RANGE_CHECK_EN
  logic f7_ok;

  // funct7 bits only carry meaning for R-type and the I-type shifts
  assign f7_ok = (fields.opcode[15:10] == 6'd0) || (op == OP_R) ||
                 ((op == OP_I) && ((f3 == 3'b001) || (f3 == 3'b101)));

  always_comb begin
    range_fault = !f7_ok;
    case (op)
      OP_I, OP_LOAD, OP_JALR, OP_S:
        if (imm[31:12] != '0) range_fault = 1'b1;
      OP_B:
        if (imm[0] || (imm[31:13] != '0)) range_fault = 1'b1;
      OP_LUI, OP_AUIPC:
        if (imm[11:0] != '0) range_fault = 1'b1;
      OP_JAL:
        if (imm[0] || (imm[31:21] != '0)) range_fault = 1'b1;
      default: ;
    endcase
  end
`else
  assign range_fault = 1'b0;
`endif

  assign word = (illegal || range_fault) ? NOP_WORD : raw;

endmodule

// File: rtl/inst_encode.sv
// RV32I instruction encoder/writer: packs field bundles and streams words into IMEM
// at an auto-incrementing address. Optional macro: INST_ENCODE_RANGE_CHECK_EN.
module inst_encode
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [15:0]       opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  count
);

  enc_state_t   state;
  inst_fields_t fields;
  logic [31:0]  pk_word;
  logic         pk_illegal;
  logic         pk_range;
  logic         accept;
  logic         wr_ack;

  assign fields = {opcode, rd, rs1, rs2, imm};

  inst_pack u_pack (
    .fields      (fields),
    .word        (pk_word),
    .illegal     (pk_illegal),
    .range_fault (pk_range)
  );

  // single output register: a new bundle may enter only as the held word leaves
  assign in_ready = (state == ST_RUN) && (!imem_we || imem_ready);
  assign accept   = in_valid && in_ready;
  assign wr_ack   = imem_we && imem_ready;
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      count      <= '0;
    end else begin
      done <= 1'b0;

      if (wr_ack) begin
        imem_addr <= imem_addr + ADDR_W'(4);
        count     <= count + CNT_W'(1);
      end

      if (accept) begin
        imem_we    <= 1'b1;
        imem_wdata <= pk_word;
        if (pk_illegal || pk_range) err <= 1'b1;
      end else if (wr_ack) begin
        imem_we <= 1'b0;
      end

      case (state)
        ST_IDLE:
          if (start) begin
            state     <= ST_RUN;
            err       <= 1'b0;
            count     <= '0;
            imem_addr <= base_addr & ~ADDR_W'(3);
          end
        ST_RUN:
          if (accept && in_last) state <= ST_DRAIN;
        ST_DRAIN:
          if (!imem_we || imem_ready) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        default:
          state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encode.sv
// Directed bench for inst_encode: hand-computed RV32I words, addresses, stalls,
// illegal opcodes, address wrap, done pulse and async reset mid-write.
module tb_inst_encode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [15:0] opcode = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;
  logic        imem_we;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy, done, err;
  logic [15:0] count;

  inst_encode #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          done_total = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];
  int          wc_q[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && imem_we && imem_ready) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      wc_q.push_back(cyc);
    end
  end

  always @(negedge clk) if (done) done_total++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h want %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] a,
                        input logic [31:0] d);
    if (idx < wa_q.size()) begin
      chk({tag, "_addr"}, wa_q[idx], a);
      chk({tag, "_data"}, wd_q[idx], d);
    end else begin
      chk({tag, "_missing"}, wa_q.size(), idx + 1);
    end
  endtask

  task automatic do_start(input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input logic [15:0] op, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [31:0] im, input logic last);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; imm = im; in_last = last; in_valid = 1'b1;
  endtask

  task automatic send(input logic [15:0] op, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [31:0] im, input logic last);
    int n;
    drive(op, d, s1, s2, im, last);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_done(input int snap);
    int n;
    n = 0;
    while (!done && n < 50) begin @(negedge clk); n++; end
    chk("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
    chk("done_pulses", done_total - snap, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  int i0, snap;
  logic [31:0] beq7_exp;
  logic        beq7_err;

  initial begin
`ifdef INST_ENCODE_RANGE_CHECK_EN
    beq7_exp = 32'h0000_0013; beq7_err = 1'b1;
`else
    beq7_exp = 32'h0020_8363; beq7_err = 1'b0;
`endif
    #12;
    chk("rst_we",    {31'd0, imem_we}, 32'd0);
    chk("rst_addr",  imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_count", {16'd0, count}, 32'd0);
    rst_n = 1'b1;

    // add x3,x1,x2; misaligned base forced down; second start in RUN ignored
    i0 = wa_q.size(); snap = done_total;
    do_start(32'h0000_0103);
    chk("p1_addr0", imem_addr, 32'h0000_0100);
    chk("p1_busy",  {31'd0, busy}, 32'd1);
    do_start(32'h0000_0800);
    send(16'h0033, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    idle();
    wait_done(snap);
    chk("p1_nwr", wa_q.size() - i0, 32'd1);
    chk_wr("p1_add", i0, 32'h0000_0100, 32'h0020_81B3);
    chk("p1_count", {16'd0, count}, 32'd1);
    chk("p1_err", {31'd0, err}, 32'd0);

    // sub then addi back-to-back
    i0 = wa_q.size(); snap = done_total;
    do_start(32'h0000_0100);
    send(16'h8033, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    send(16'h0013, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    idle();
    wait_done(snap);
    chk("p2_nwr", wa_q.size() - i0, 32'd2);
    chk_wr("p2_sub", i0, 32'h0000_0100, 32'h4020_81B3);
    chk_wr("p2_addi", i0 + 1, 32'h0000_0104, 32'h0050_0093);
    if (wc_q.size() >= i0 + 2) chk("p2_rate", wc_q[i0+1] - wc_q[i0], 32'd1);
    chk("p2_count", {16'd0, count}, 32'd2);

    // lui, jal, beq, jalr (junk funct3), sw
    i0 = wa_q.size(); snap = done_total;
    do_start(32'h0000_0300);
    send(16'h0037, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
    send(16'h006F, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
    send(16'h0063, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    send(16'h0367, 5'd1, 5'd2, 5'd0, 32'd4, 1'b0);
    send(16'h0123, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1);
    idle();
    wait_done(snap);
    chk("p3_nwr", wa_q.size() - i0, 32'd5);
    chk_wr("p3_lui",  i0,     32'h0000_0300, 32'h1234_52B7);
    chk_wr("p3_jal",  i0 + 1, 32'h0000_0304, 32'h0080_00EF);
    chk_wr("p3_beq",  i0 + 2, 32'h0000_0308, 32'h0020_8463);
    chk_wr("p3_jalr", i0 + 3, 32'h0000_030C, 32'h0041_00E7);
    chk_wr("p3_sw",   i0 + 4, 32'h0000_0310, 32'h0020_A423);
    chk("p3_count", {16'd0, count}, 32'd5);

    // memory stall for 3 cycles with a bundle pending
    i0 = wa_q.size(); snap = done_total;
    do_start(32'h0000_0400);
    imem_ready = 1'b0;
    send(16'h8033, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    drive(16'h0033, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      chk("p4_rdy",  {31'd0, in_ready}, 32'd0);
      chk("p4_we",   {31'd0, imem_we}, 32'd1);
      chk("p4_addr", imem_addr, 32'h0000_0400);
      chk("p4_data", imem_wdata, 32'h4020_81B3);
      @(negedge clk);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    idle();
    wait_done(snap);
    chk("p4_nwr", wa_q.size() - i0, 32'd2);
    chk_wr("p4_sub", i0,     32'h0000_0400, 32'h4020_81B3);
    chk_wr("p4_add", i0 + 1, 32'h0000_0404, 32'h0020_81B3);
    chk("p4_count", {16'd0, count}, 32'd2);

    // illegal opcode: NOP written, counted, err sticky
    i0 = wa_q.size(); snap = done_total;
    do_start(32'h0000_0500);
    send(16'h007F, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    idle();
    wait_done(snap);
    chk_wr("p5_nop", i0, 32'h0000_0500, 32'h0000_0013);
    chk("p5_err", {31'd0, err}, 32'd1);
    chk("p5_count", {16'd0, count}, 32'd1);

    // start clears err; beq with odd immediate
    i0 = wa_q.size(); snap = done_total;
    do_start(32'h0000_0600);
    chk("p6_err_clr", {31'd0, err}, 32'd0);
    chk("p6_cnt_clr", {16'd0, count}, 32'd0);
    send(16'h0063, 5'd0, 5'd1, 5'd2, 32'd7, 1'b1);
    idle();
    wait_done(snap);
    chk_wr("p6_beq7", i0, 32'h0000_0600, beq7_exp);
    chk("p6_err", {31'd0, err}, {31'd0, beq7_err});

    // address wraps past the top of the space
    i0 = wa_q.size(); snap = done_total;
    do_start(32'hFFFF_FFFE);
    send(16'h0013, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    send(16'h0013, 5'd1, 5'd0, 5'd0, 32'd1, 1'b1);
    idle();
    wait_done(snap);
    chk_wr("p7_hi", i0,     32'hFFFF_FFFC, 32'h0050_0093);
    chk_wr("p7_lo", i0 + 1, 32'h0000_0000, 32'h0010_0093);
    chk("p7_err", {31'd0, err}, 32'd0);

    // async reset while a write is stalled
    do_start(32'h0000_0700);
    imem_ready = 1'b0;
    send(16'h0033, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
    idle();
    chk("p8_we_pre", {31'd0, imem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("p8_we_rst",   {31'd0, imem_we}, 32'd0);
    chk("p8_busy_rst", {31'd0, busy}, 32'd0);
    chk("p8_addr_rst", imem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; imem_ready = 1'b1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
